// File: rtl/shift_pkg.sv
// Shared definitions for the sequential right shifter: FSM encoding and default sizes.
package shift_pkg;

   localparam int unsigned DefaultWidth  = 32;
   localparam int unsigned DefaultShamtW = 5;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

endpackage

// File: rtl/sequential_shift_right.sv
// Multi-cycle right shifter: one bit per clock, logical or arithmetic fill,
// fixed latency of Shamt+2 cycles from the Start cycle to the Done pulse.
module sequential_shift_right
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH   = DefaultWidth,
   parameter int unsigned SHAMT_W = DefaultShamtW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Start,
   input  logic [WIDTH-1:0]   DataInput,
   input  logic [SHAMT_W-1:0] Shamt,
   input  logic               Arithmetic,
   output logic [WIDTH-1:0]   DataOutput,
   output logic               Busy,
   output logic               Done
);

   state_e             state_q;
   logic [WIDTH-1:0]   work_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               fill_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         work_q     <= '0;
         cnt_q      <= '0;
         fill_q     <= 1'b0;
         DataOutput <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (Start) begin
                  work_q  <= DataInput;
                  cnt_q   <= Shamt;
                  fill_q  <= Arithmetic;
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (cnt_q != '0) begin
                  // Sign fill only when the arithmetic mode was captured.
                  work_q <= {fill_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
                  cnt_q  <= cnt_q - SHAMT_W'(1);
               end else begin
                  DataOutput <= work_q;
                  state_q    <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign Busy = (state_q == StShift) || (state_q == StDone);
   assign Done = (state_q == StDone);

endmodule

// File: tb/tb_sequential_shift_right.sv
// Randomised self-checking bench for sequential_shift_right against a plain >> / >>> model.
module tb_sequential_shift_right;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        arith;
   logic [31:0] data_out;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   sequential_shift_right #(
      .WIDTH   (32),
      .SHAMT_W (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .Start      (start),
      .DataInput  (data_in),
      .Shamt      (shamt),
      .Arithmetic (arith),
      .DataOutput (data_out),
      .Busy       (busy),
      .Done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic ar);
      if (ar) return 32'($signed(d) >>> sh);
      return d >> sh;
   endfunction

   // Latency counts rising edges from the accepting edge up to the edge after which Done is seen.
   task automatic run_op(input logic [31:0] d, input int sh, input logic ar,
                         output logic [31:0] res, output int lat);
      int guard = 0;
      while (busy && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      data_in = d;
      shamt   = 5'(sh);
      arith   = ar;
      start   = 1'b1;
      @(posedge clk); #1;
      lat   = 1;
      start = 1'b0;
      data_in = $urandom;
      shamt   = 5'($urandom);
      arith   = 1'($urandom);
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = data_out;
   endtask

   task automatic op_and_check(input string tag, input logic [31:0] d, input int sh, input logic ar);
      logic [31:0] res;
      int          lat;
      run_op(d, sh, ar, res, lat);
      check_eq({tag, " done"}, 32'(done), 32'd1);
      check_eq({tag, " result"}, res, ref_shift(d, sh, ar));
      check_eq({tag, " latency"}, 32'(lat), 32'(sh + 2));
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] first_res;
      int          lat;
      int          n_done;

      reset   = 1'b0;
      start   = 1'b0;
      data_in = '0;
      shamt   = '0;
      arith   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset data_out", data_out, 32'h0);
      check_eq("reset busy", 32'(busy), 32'd0);
      check_eq("reset done", 32'(done), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed cases, including checks on the Done pulse width and output hold.
      run_op(32'h8000_0000, 4, 1'b1, res, lat);
      check_eq("t1 result", res, 32'hF800_0000);
      check_eq("t1 latency", 32'(lat), 32'd6);
      @(posedge clk); #1;
      check_eq("t1 done one cycle", 32'(done), 32'd0);
      check_eq("t1 idle busy", 32'(busy), 32'd0);
      check_eq("t1 output held", data_out, 32'hF800_0000);

      run_op(32'h8000_0000, 4, 1'b0, res, lat);
      check_eq("t2a result", res, 32'h0800_0000);
      run_op(32'hFFFF_FFFF, 31, 1'b0, res, lat);
      check_eq("t2b result", res, 32'h0000_0001);
      check_eq("t2b latency", 32'(lat), 32'd33);

      run_op(32'h1234_5678, 0, 1'b1, res, lat);
      check_eq("t3 result", res, 32'h1234_5678);
      check_eq("t3 latency", 32'(lat), 32'd2);

      // Start while busy must be dropped, not queued.
      @(posedge clk); #1;
      data_in = 32'h8000_00F0; shamt = 5'd8; arith = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      data_in = 32'h0000_FFFF; shamt = 5'd1; arith = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_done    = 0;
      first_res = 32'h0;
      for (int i = 0; i < 60; i++) begin
         if (done) begin
            n_done++;
            if (n_done == 1) first_res = data_out;
         end
         @(posedge clk); #1;
      end
      check_eq("t4 done count", 32'(n_done), 32'd1);
      check_eq("t4 result", first_res, ref_shift(32'h8000_00F0, 8, 1'b1));

      // Back-to-back: Start in the IDLE cycle right after DONE.
      run_op(32'hA5A5_0000, 3, 1'b0, res, lat);
      check_eq("t4 b2b first", res, 32'h14B4_A000);
      @(posedge clk); #1;
      check_eq("t4 b2b idle", 32'(busy), 32'd0);
      data_in = 32'h0F0F_0F0F; shamt = 5'd2; arith = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("t4 b2b accepted", 32'(busy), 32'd1);
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("t4 b2b result", data_out, 32'h03C3_C3C3);
      check_eq("t4 b2b latency", 32'(lat), 32'd4);

      // Reset in the third SHIFT cycle aborts asynchronously with no Done.
      @(posedge clk); #1;
      data_in = 32'hFFFF_0000; shamt = 5'd20; arith = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_eq("t5 async data_out", data_out, 32'h0);
      check_eq("t5 async busy", 32'(busy), 32'd0);
      check_eq("t5 async done", 32'(done), 32'd0);
      n_done = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check_eq("t5 no done", 32'(n_done), 32'd0);
      op_and_check("t5 after reset", 32'h0000_00F0, 4, 1'b0);

      // Random operands over every shift amount and both fill modes.
      for (int sh = 0; sh < 32; sh++) begin
         for (int m = 0; m < 2; m++) begin
            logic [31:0] d;
            d = $urandom;
            if ((sh % 4) == 0) d[31] = 1'b1;
            run_op(d, sh, 1'(m), res, lat);
            check_eq($sformatf("rand sh=%0d ar=%0d result", sh, m), res, ref_shift(d, sh, 1'(m)));
            check_eq($sformatf("rand sh=%0d ar=%0d latency", sh, m), 32'(lat), 32'(sh + 2));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
